// File: rtl/gpr_pkg.sv
// Shared definitions for the general register file writeback path.
package gpr_pkg;

  localparam int GPR_ADDR_W = 5;
  localparam int GPR_DATA_W = 32;
  localparam int NUM_GPR    = 32;

  // Writeback requester slots on the shared write port
  typedef enum logic [2:0] {
    REQ_ALU    = 3'd0,
    REQ_LOAD   = 3'd1,
    REQ_MULDIV = 3'd2
  } req_idx_e;

  typedef struct packed {
    logic [GPR_ADDR_W-1:0] addr;
    logic [GPR_DATA_W-1:0] data;
  } gpr_wr_t;

  // (a + b) mod n for operands already in [0, n-1]
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/gpr_write_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after
// rr_ptr, pointer moves just past the winner on every grant.
module rr_arbiter
  import gpr_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] ptr_nxt;
  logic             found;

  // Scan offsets 0..NUM_REQ-1 from rr_ptr; grant is forced low during reset
  always_comb begin
    grant   = '0;
    found   = 1'b0;
    ptr_nxt = rr_ptr;
    if (enable && resetn) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        for (int j = 0; j < NUM_REQ; j++) begin
          if (!found && req[j] && (j == wrap_add(int'(rr_ptr), i, NUM_REQ))) begin
            grant[j] = 1'b1;
            ptr_nxt  = PTR_W'(wrap_add(j, 1, NUM_REQ));
            found    = 1'b1;
          end
        end
      end
    end
  end

  // Pointer register; holds whenever nothing is granted
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rr_ptr <= '0;
    end else begin
      rr_ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/gpr_write_arbiter.sv
// Shares the register file write port among NUM_REQ writeback sources.
// The winning address/data is registered and presented on the port for
// exactly one cycle; writes to register 0 are absorbed and counted.
module gpr_write_arbiter
  import gpr_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = GPR_ADDR_W,
  parameter int DATA_W  = GPR_DATA_W
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      stall,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      gr_write_enable,
  output logic [ADDR_W-1:0]         gr_write_add,
  output logic [DATA_W-1:0]         gr_write,
  output logic                      inflight_valid,
  output logic [7:0]                drop_count
);

  logic [NUM_REQ-1:0] grant_p0;
  logic               vld_p0;
  logic [ADDR_W-1:0]  addr_p0;
  logic [DATA_W-1:0]  data_p0;

  logic               vld_p1;
  logic [ADDR_W-1:0]  addr_p1;
  logic [DATA_W-1:0]  data_p1;
  logic [7:0]         drop_cnt;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : (v + 8'd1);
  endfunction

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clock  (clock),
    .resetn (resetn),
    .enable (!stall),
    .req    (req_valid),
    .grant  (grant_p0)
  );

  assign req_ready = grant_p0;

  // Stage p0: select the granted requester's address and data
  always_comb begin
    vld_p0  = |grant_p0;
    addr_p0 = '0;
    data_p0 = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (grant_p0[j]) begin
        addr_p0 = req_addr[j*ADDR_W +: ADDR_W];
        data_p0 = req_data[j*DATA_W +: DATA_W];
      end
    end
  end

  // Stage p1: port register and register-0 drop counter
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      vld_p1   <= 1'b0;
      addr_p1  <= '0;
      data_p1  <= '0;
      drop_cnt <= '0;
    end else begin
      vld_p1 <= vld_p0 && (addr_p0 != '0);
      if (vld_p0) begin
        addr_p1 <= addr_p0;
        data_p1 <= data_p0;
      end
      if (vld_p0 && (addr_p0 == '0)) begin
        drop_cnt <= sat_inc(drop_cnt);
      end
    end
  end

  assign gr_write_enable = vld_p1;
  assign inflight_valid  = vld_p1;
  assign gr_write_add    = addr_p1;
  assign gr_write        = data_p1;
  assign drop_count      = drop_cnt;

endmodule

// File: tb/tb_gpr_write_arbiter.sv
// Randomised bench for gpr_write_arbiter with a behavioural reference model.
module tb_gpr_write_arbiter;
  import gpr_pkg::*;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic              clock = 1'b0;
  logic              resetn;
  logic              stall;
  logic [N-1:0]      req_valid;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              gr_write_enable;
  logic [AW-1:0]     gr_write_add;
  logic [DW-1:0]     gr_write;
  logic              inflight_valid;
  logic [7:0]        drop_count;

  gpr_write_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock           (clock),
    .resetn          (resetn),
    .stall           (stall),
    .req_valid       (req_valid),
    .req_addr        (req_addr),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .gr_write_enable (gr_write_enable),
    .gr_write_add    (gr_write_add),
    .gr_write        (gr_write),
    .inflight_valid  (inflight_valid),
    .drop_count      (drop_count)
  );

  always #5 clock = ~clock;

  // Requester-side stimulus
  logic [N-1:0]  vv;
  logic [AW-1:0] aa [N];
  logic [DW-1:0] dd [N];

  // Reference model state
  int           m_ptr;
  bit           m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int           m_drop;
  int           last_g;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    req_valid = vv;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = aa[i];
      req_data[i*DW +: DW] = dd[i];
    end
  endtask

  function automatic int model_grant();
    if (stall || !resetn) return -1;
    for (int k = 0; k < N; k++) begin
      if (vv[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  // One clock of stimulus + check; starts and ends just after a rising edge
  task automatic cycle();
    int g;
    logic [N-1:0] er;
    drive();
    #1;
    g  = model_grant();
    er = (g >= 0) ? (N'(1) << g) : '0;
    chk("req_ready", 64'(req_ready), 64'(er));
    @(posedge clock);
    #1;
    if (g >= 0) begin
      m_ptr  = (g + 1) % N;
      m_we   = (aa[g] != '0);
      m_addr = aa[g];
      m_data = dd[g];
      if (aa[g] == '0 && m_drop < 255) m_drop++;
    end else begin
      m_we = 1'b0;
    end
    chk("we", 64'(gr_write_enable), 64'(m_we));
    chk("inflight", 64'(inflight_valid), 64'(m_we));
    if (m_we) begin
      chk("addr", 64'(gr_write_add), 64'(m_addr));
      chk("data", 64'(gr_write), 64'(m_data));
    end
    chk("drop", 64'(drop_count), 64'(m_drop));
    last_g = g;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_we"},    64'(gr_write_enable), 64'd0);
    chk({tag, "_add"},   64'(gr_write_add),    64'd0);
    chk({tag, "_data"},  64'(gr_write),        64'd0);
    chk({tag, "_infl"},  64'(inflight_valid),  64'd0);
    chk({tag, "_drop"},  64'(drop_count),      64'd0);
    chk({tag, "_ready"}, 64'(req_ready),       64'd0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    stall  = 1'b0;
    vv     = '1;
    for (int i = 0; i < N; i++) begin
      aa[i] = AW'(i + 1);
      dd[i] = DW'(i);
    end
    drive();
    @(posedge clock);
    #1;
    check_reset_outputs("rst");
    vv = '0;
    drive();
    m_ptr = 0; m_we = 1'b0; m_drop = 0; m_addr = '0; m_data = '0;
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    chk("release_we", 64'(gr_write_enable), 64'd0);
  endtask

  initial begin
    last_g = -1;
    do_reset();

    // Single request from the load unit
    vv = '0;
    vv[int'(REQ_LOAD)] = 1'b1;
    aa[int'(REQ_LOAD)] = 5'd7;
    dd[int'(REQ_LOAD)] = 32'hDEADBEEF;
    cycle();
    chk("single_grant", 64'(last_g), 64'(int'(REQ_LOAD)));
    chk("single_we", 64'(gr_write_enable), 64'd1);
    chk("single_add", 64'(gr_write_add), 64'd7);
    chk("single_data", 64'(gr_write), 64'hDEADBEEF);
    vv = '0;
    cycle();
    chk("single_we_off", 64'(gr_write_enable), 64'd0);

    // All requesters continuously valid: strict rotation
    do_reset();
    vv = '1;
    for (int i = 0; i < N; i++) begin
      aa[i] = AW'(i + 1);
      dd[i] = DW'($urandom);
    end
    for (int i = 0; i < 9; i++) begin
      cycle();
      chk("rr_seq", 64'(last_g), 64'(i % N));
      chk("rr_addr", 64'(gr_write_add), 64'((i % N) + 1));
    end

    // Register 0 writes are accepted but never reach the port
    do_reset();
    vv = '0;
    vv[int'(REQ_ALU)] = 1'b1;
    aa[int'(REQ_ALU)] = '0;
    dd[int'(REQ_ALU)] = 32'h12345678;
    cycle();
    chk("r0_grant", 64'(last_g), 64'd0);
    chk("r0_we", 64'(gr_write_enable), 64'd0);
    chk("r0_drop", 64'(drop_count), 64'd1);
    vv = '1;
    aa[1] = 5'd9;
    aa[2] = 5'd10;
    cycle();
    chk("r0_ptr_adv", 64'(last_g), 64'd1);
    vv = 3'b001;
    for (int i = 0; i < 300; i++) cycle();
    chk("drop_sat", 64'(drop_count), 64'd255);

    // Stall freezes grants; release serves 0 then 2
    do_reset();
    vv = 3'b101;
    aa[0] = 5'd4; aa[2] = 5'd6;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_we", 64'(gr_write_enable), 64'd0);
    end
    stall = 1'b0;
    cycle();
    chk("stall_rel0", 64'(last_g), 64'd0);
    vv = 3'b100;
    cycle();
    chk("stall_rel2", 64'(last_g), 64'd2);

    // Reset asserted while a write sits in the port register
    vv = 3'b010;
    aa[1] = 5'd12;
    cycle();
    chk("mid_we_before", 64'(gr_write_enable), 64'd1);
    resetn = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    vv = '0;
    drive();
    m_ptr = 0; m_we = 1'b0; m_drop = 0;
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    chk("mid_release_we", 64'(gr_write_enable), 64'd0);
    vv = 3'b011;
    aa[0] = 5'd3;
    cycle();
    chk("mid_first_grant", 64'(last_g), 64'd0);

    // Random traffic: held requests, register-0 writes, random stalls
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!vv[i] || last_g == i) begin
          vv[i] = ($urandom_range(0, 2) != 0);
          aa[i] = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, 31));
          dd[i] = DW'($urandom);
        end
      end
      stall = ($urandom_range(0, 4) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule

// File: doc/gpr_write_arbiter.md
# gpr_write_arbiter

Shares the single write port of the 32×32 general register file between several writeback requesters (ALU, load unit, multiply/divide unit). Each cycle it grants at most one valid request by round-robin, registers the winning address/data, and drives the register file write port one cycle later. It also reports which register is currently in flight.

## Interface
Parameters:
- NUM_REQ, 3: number of writeback requesters, 2..8.
- ADDR_W, 5: register address width.
- DATA_W, 32: write data width.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- stall  in  1  freeze: no grants while high.
- req_valid  in  NUM_REQ  per-requester write request.
- req_addr  in  NUM_REQ*ADDR_W  destination register; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_data  in  NUM_REQ*DATA_W  write data, packed the same way.
- req_ready  out  NUM_REQ  one-hot grant. A transfer happens when valid and ready are both high.
- gr_write_enable  out  1  register file write enable.
- gr_write_add  out  ADDR_W  register file write address.
- gr_write  out  DATA_W  register file write data.
- inflight_valid  out  1  a write is on the port this cycle (equals gr_write_enable).
- drop_count  out  8  count of accepted writes to register 0, saturating.

## Operation
- Round-robin pointer rr_ptr ∈ [0, NUM_REQ-1], reset to 0.
- Priority order: rr_ptr, rr_ptr+1, … (mod NUM_REQ).
- When stall=0, the first valid requester in priority order is granted. req_ready for that requester is high combinationally in the same cycle.
- Grant is combinational on req_valid, stall and rr_ptr.
- req_ready may depend on req_valid. Requesters must hold valid, addr and data stable until the handshake completes.
- On a grant to requester g:
  - rr_ptr ← (g+1) mod NUM_REQ at the next edge.
  - The output register captures addr/data from requester g.
- With no grant, rr_ptr holds.
- Register 0 handling: a request with addr 0 is accepted normally and rr_ptr advances, but gr_write_enable stays 0 on the following cycle. drop_count increments and saturates at 255.
- When stall=1: all req_ready are 0, rr_ptr holds, and no new write is issued. A write already registered still appears on the port in its cycle.
- Simultaneous requests are never lost; losers keep valid asserted and are served in later cycles.

## Timing
- Grant to port latency: 1 cycle. A handshake at edge N puts gr_write_enable, gr_write_add and gr_write valid from edge N until edge N+1. The register file commits at edge N+1.
- gr_write_enable is a single-cycle pulse per accepted non-zero write.
- Maximum throughput is 1 write per cycle.
- Fairness: with all requesters continuously valid, each is granted exactly once every NUM_REQ cycles.
- Reset values (asynchronous, resetn=0):
  - rr_ptr=0
  - gr_write_enable=0
  - gr_write_add=0
  - gr_write=0
  - drop_count=0
  - inflight_valid=0
- req_ready is 0 while resetn=0.
- Reset asserted mid-operation discards the registered write with no port pulse. Requesters must re-present their requests after reset.
- Deasserting resetn does not by itself produce a write; the first grant can occur in the first cycle after release.

## Structure
- Shared package gpr_pkg:
  - GPR_ADDR_W=5, GPR_DATA_W=32, NUM_GPR=32.
  - Requester index enum: REQ_ALU=0, REQ_LOAD=1, REQ_MULDIV=2.
  - gpr_wr_t struct {addr, data}.
- Sub-module rr_arbiter: parameterised NUM_REQ.
  - Inputs: req vector, enable, clock, resetn.
  - Outputs: one-hot grant; owns rr_ptr.
  - The top level owns the output register and drop_count.

## Test plan
- Single request: REQ_LOAD valid, addr 7, data 0xDEADBEEF at edge N.
  - Expect req_ready[1] high in that cycle.
  - Next cycle: gr_write_enable=1, add=7, data=0xDEADBEEF.
  - Then enable=0.
- All three requesters continuously valid, addrs 1/2/3, for 9 cycles.
  - Expect grant sequence 0,1,2,0,1,2,0,1,2.
  - Port addresses 1,2,3,… each one cycle after its grant.
- Register 0: REQ_ALU writes addr 0, data 0x12345678.
  - Expect handshake and no gr_write_enable pulse.
  - drop_count=1; rr_ptr advances to 1.
  - After 300 such writes, drop_count=255.
- Stall: requesters 0 and 2 valid, stall=1 for 3 cycles.
  - Expect req_ready=0 and no port writes; rr_ptr unchanged.
  - On release, requester 0 is granted first, then 2.
- Reset mid-operation: grant at edge N, resetn pulled low before edge N+1.
  - Expect gr_write_enable=0 immediately and all outputs at reset values.
  - After release, the first valid requester is granted from rr_ptr=0.
